// File: rtl/dct_uart_pkg.sv
// Shared constants and state encodings for the DCT UART return path.
package dct_uart_pkg;
  localparam int         PAYLOAD_BYTES = 32;
  localparam int         WORD_W        = 32;
  localparam logic [7:0] SYNC_BYTE     = 8'hA5;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {CTL_IDLE, CTL_LOAD, CTL_WAIT} ctl_state_e;
endpackage

// File: rtl/uart_tx_byte.sv
// Bit-level 8N1 UART transmitter: one byte per byte_start, LSB first.
module uart_tx_byte
  import dct_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       byte_done
);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (byte_start) begin
            shift_q <= byte_in;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= TX_DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        TX_DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        TX_STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= TX_IDLE;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  // Decoded in the last stop-bit cycle so the controller reacts on the edge the stop bit ends.
  assign byte_done = (state_q == TX_STOP) && (baud_q == BAUD_LAST);
  assign tx        = tx_q;
endmodule

// File: rtl/dct_result_tx.sv
// Captures a 256-bit DCT result and serializes it as 8N1 UART bytes, g0 MSB byte first.
// Optional framing (sync 0xA5 + payload + XOR checksum) when DCT_TX_FRAME_EN is defined.
module dct_result_tx
  import dct_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         done_in,
  input  logic [255:0] data_in,
  output logic         tx,
  output logic         busy,
  output logic         overflow
);
`ifdef DCT_TX_FRAME_EN
  localparam int             CNT_W    = 6;
  localparam logic [CNT_W-1:0] LAST_IDX = 6'd33;
`else
  localparam int             CNT_W    = 5;
  localparam logic [CNT_W-1:0] LAST_IDX = 5'd31;
`endif
  localparam int HOLD_W = 8 * WORD_W;

  ctl_state_e        state_q;
  logic [HOLD_W-1:0] hold_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        byte_q;
  logic              byte_start_q;
  logic              busy_q;
  logic              ovf_q;
  logic              byte_done;
  logic [4:0]        pidx;
  logic [7:0]        cur_byte;

`ifdef DCT_TX_FRAME_EN
  logic [7:0] csum_q;
  logic       is_payload;
  assign pidx       = 5'(cnt_q - 6'd1);
  assign is_payload = (cnt_q != '0) && (cnt_q != LAST_IDX);
`else
  assign pidx = cnt_q;
`endif

  always_comb begin
    cur_byte = hold_q[{5'(PAYLOAD_BYTES - 1) - pidx, 3'b000} +: 8];
`ifdef DCT_TX_FRAME_EN
    if (cnt_q == '0)           cur_byte = SYNC_BYTE;
    else if (cnt_q == LAST_IDX) cur_byte = csum_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= CTL_IDLE;
      hold_q       <= '0;
      cnt_q        <= '0;
      byte_q       <= '0;
      byte_start_q <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
`ifdef DCT_TX_FRAME_EN
      csum_q       <= '0;
`endif
    end else begin
      byte_start_q <= 1'b0;
      // busy is judged by its registered value, so a result on the falling edge is dropped.
      if (done_in && busy_q) ovf_q <= 1'b1;
      case (state_q)
        CTL_IDLE: begin
          if (done_in && !busy_q) begin
            hold_q  <= data_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CTL_LOAD;
`ifdef DCT_TX_FRAME_EN
            csum_q  <= '0;
`endif
          end
        end
        CTL_LOAD: begin
          byte_q       <= cur_byte;
          byte_start_q <= 1'b1;
          state_q      <= CTL_WAIT;
`ifdef DCT_TX_FRAME_EN
          if (is_payload) csum_q <= csum_q ^ cur_byte;
`endif
        end
        CTL_WAIT: begin
          if (byte_done) begin
            if (cnt_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              state_q <= CTL_IDLE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= CTL_LOAD;
            end
          end
        end
        default: state_q <= CTL_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_start(byte_start_q),
    .byte_in   (byte_q),
    .tx        (tx),
    .byte_done (byte_done)
  );

  assign busy     = busy_q;
  assign overflow = ovf_q;
endmodule

// File: doc/dct_result_tx.md
# dct_result_tx

Downstream stage of the 8-point DCT core: captures the 256-bit result vector (eight 32-bit IEEE-754 words) on the core's one-cycle `done` pulse and serializes it as 8N1 UART bytes on a single `tx` line. Sits between the DCT core output and the board TX pin. It is the return path of the UART-fed DCT datapath.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `done_in` in 1: one-cycle result-valid pulse from the DCT core.
- `data_in` in 256: DCT result; word g0 in [255:224] through g7 in [31:0]; valid only in the `done_in` cycle.
- `tx` out 1: UART serial output, idle high.
- `busy` out 1: high from capture until the last stop bit completes.
- `overflow` out 1: sticky; a result arrived while busy and was dropped.

## Operation
- Controller states: IDLE, LOAD, WAIT.
- IDLE: on `done_in`=1, latch `data_in` into a 256-bit hold register, clear byte counter, go to LOAD; `busy`=1 from that edge.
- LOAD: pulse `byte_start` to the bit transmitter with the current byte; go to WAIT.
- WAIT: on the transmitter's `byte_done`, increment the counter; last byte sent -> IDLE (`busy`=0), else -> LOAD.
- Byte order: [255:248] first, [7:0] last (big-endian per word, g0 first). Bits within a byte: LSB first.
- Frame per byte: start bit (0), 8 data bits, one stop bit (1); each bit exactly `CLKS_PER_BIT` cycles.
- Transmitter states: IDLE, START, DATA, STOP; 16-bit baud counter, 3-bit bit index. `byte_done` pulses one cycle at the edge the STOP bit period ends; `tx` high from that edge.
- `done_in` while `busy`=1 (including the capture cycle's successor and the final stop bit): input ignored, `overflow` set to 1; in-progress frame continues unchanged.
- `done_in` in the same cycle that `busy` falls: dropped, `overflow` set (busy is evaluated as registered).
- `overflow` clears only on reset.
- Reset mid-frame: all state returns to IDLE at that edge, `tx`=1, no partial-byte completion.

## Timing
- Reset values: `tx`=1, `busy`=0, `overflow`=0; hold register, counters 0.
- `done_in` sampled high at edge N: `busy`=1 after N; `byte_start` at edge N+1; `tx` falls at edge N+2.
- Each byte occupies 10*`CLKS_PER_BIT` cycles of line time, followed by 2 idle-high cycles (WAIT->LOAD, LOAD->START) before the next start bit.
- Total, payload only: 32*(10*C+2) cycles from edge N+2 start-bit edge minus the trailing 2 idle cycles; `busy` falls at the edge the last stop bit ends.
- Next `done_in` accepted one cycle after `busy` is observed low.

## Configuration
- `DCT_TX_FRAME_EN` defined: frame becomes 34 bytes: sync byte 0xA5, 32 payload bytes, then XOR of the 32 payload bytes (sync excluded). Byte counter 6 bits.
- Undefined: 32 raw payload bytes only, no sync, no checksum; checksum logic absent.

## Structure
- Package `dct_uart_pkg`: `PAYLOAD_BYTES`=32, `WORD_W`=32, `SYNC_BYTE`=8'hA5, transmitter state encoding.
- Sub-module `uart_tx_byte`: bit-level 8N1 transmitter (`clk`, `rst_n`, `byte_start`, `byte_in[7:0]`, `tx`, `byte_done`), parameter `CLKS_PER_BIT`; shared with the design's other TX paths.
- Top module holds capture register, byte mux/counter, controller FSM, overflow flag, optional checksum accumulator.

## Test plan
- Reset then idle 100 cycles -> `tx`=1, `busy`=0, `overflow`=0 throughout.
- C=4, `data_in`=256'h00010203...1E1F with one `done_in` -> bytes 0x00..0x1F decoded in order, start bit at edge N+2, `busy` low after 32*42-2 cycles.
- C=4, `data_in`=all 0xFF, `DCT_TX_FRAME_EN` defined -> bytes 0xA5, 32x0xFF, checksum 0x00; undefined -> 32x0xFF only.
- Second `done_in` 50 cycles into a frame -> first frame bit-exact, second dropped, `overflow`=1 until reset.
- `rst_n`=0 for one cycle mid-byte 5 -> `tx`=1, `busy`=0 next cycle; following `done_in` sends full fresh frame.
- `done_in` on the cycle `busy` falls -> dropped, `overflow`=1; `done_in` one cycle later -> accepted normally.
